// File: rtl/dnn_pkg.sv
// rtl/dnn_pkg.sv - shared state codes and arithmetic helpers for the DNN layer sequencer
package dnn_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    function automatic int acc_width(input int in_w, input int w_w, input int n_in);
        return in_w + w_w + $clog2(n_in);
    endfunction

    function automatic logic signed [63:0] relu(input logic signed [63:0] v, input logic en);
        return (en && v < 0) ? 64'sd0 : v;
    endfunction

    // Clamp to the signed range of 'width' bits; a no-op when the value already fits.
    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/dnn_layer_seq_if.sv
// rtl/dnn_layer_seq_if.sv - input/output stream and weight-write bus of one DNN layer
interface dnn_layer_seq_if #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 4,
    parameter int IN_W  = 5,
    parameter int W_W   = 5,
    parameter int OUT_W = 12
);
    localparam int AW = $clog2(N_IN * N_OUT);

    logic                      in_valid;
    logic                      in_ready;
    logic [N_IN*IN_W-1:0]      in_data;
    logic                      relu_en;
    logic                      w_we;
    logic [AW-1:0]             w_addr;
    logic signed [W_W-1:0]     w_data;
    logic                      w_busy;
    logic                      out_valid;
    logic                      out_ready;
    logic [N_OUT*OUT_W-1:0]    out_data;

    modport master (
        output in_valid, in_data, relu_en, w_we, w_addr, w_data, out_ready,
        input  in_ready, w_busy, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, relu_en, w_we, w_addr, w_data, out_ready,
        output in_ready, w_busy, out_valid, out_data
    );
endinterface

// File: rtl/dnn_mac_lane.sv
// rtl/dnn_mac_lane.sv - one neuron: signed multiply-accumulate with ReLU and saturating output register
module dnn_mac_lane
    import dnn_pkg::*;
#(
    parameter int IN_W  = 5,
    parameter int W_W   = 5,
    parameter int ACC_W = 12,
    parameter int OUT_W = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    ld,
    input  logic                    relu_en,
    input  logic signed [IN_W-1:0]  x,
    input  logic signed [W_W-1:0]   w,
    output logic signed [OUT_W-1:0] y
);
    localparam int PW = IN_W + W_W;

    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic signed [63:0]      wide;

    assign prod = x * w;
    assign sum  = acc + {{(ACC_W - PW){prod[PW-1]}}, prod};
    assign wide = {{(64 - ACC_W){sum[ACC_W-1]}}, sum};

    // The output register takes the final sum directly, so the last product never waits in acc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            y   <= '0;
        end else begin
            if (clr) begin
                acc <= '0;
            end else if (en) begin
                acc <= sum;
            end
            if (ld) begin
                y <= OUT_W'(sat(relu(wide, relu_en), OUT_W));
            end
        end
    end

endmodule

// File: rtl/dnn_layer_seq.sv
// rtl/dnn_layer_seq.sv - time-multiplexed fully-connected layer with writable weights and stream handshakes
module dnn_layer_seq
    import dnn_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 4,
    parameter int IN_W  = 5,
    parameter int W_W   = 5,
    parameter int OUT_W = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    dnn_layer_seq_if.slave bus
);
    localparam int ACC_W = acc_width(IN_W, W_W, N_IN);
    localparam int NW    = N_IN * N_OUT;
    localparam int AW    = $clog2(NW);
    localparam int IDXW  = $clog2(N_IN);

    logic [1:0]              state;
    logic [IDXW-1:0]         idx;
    logic [N_IN*IN_W-1:0]    x_lat;
    logic                    relu_lat;
    logic                    out_valid_q;
    logic                    accept;
    logic                    last;
    logic signed [W_W-1:0]   w_mem [NW];
    logic signed [IN_W-1:0]  x_cur;
    logic signed [W_W-1:0]   w_cur [N_OUT];
    logic signed [OUT_W-1:0] lane_y [N_OUT];
    logic [N_OUT*OUT_W-1:0]  out_flat;

    // HOLD passes out_ready straight through so a consumer pop and a new vector share one edge.
    assign bus.in_ready  = (state == IDLE) || (state == HOLD && bus.out_ready);
    assign bus.w_busy    = (state == ACCUM);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_flat;
    assign accept        = bus.in_valid && bus.in_ready;
    assign last          = (state == ACCUM) && (idx == IDXW'(N_IN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            x_lat       <= '0;
            relu_lat    <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            x_lat       <= bus.in_data;
            relu_lat    <= bus.relu_en;
            idx         <= '0;
            out_valid_q <= 1'b0;
            state       <= ACCUM;
        end else begin
            case (state)
                ACCUM: begin
                    if (last) begin
                        state       <= HOLD;
                        out_valid_q <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Out-of-range addresses match no entry and fall through untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NW; k++) w_mem[k] <= '0;
        end else if (bus.w_we && state != ACCUM) begin
            for (int k = 0; k < NW; k++) begin
                if (bus.w_addr == AW'(k)) w_mem[k] <= bus.w_data;
            end
        end
    end

    always_comb begin
        x_cur = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (idx == IDXW'(i)) x_cur = x_lat[i*IN_W +: IN_W];
        end
        for (int j = 0; j < N_OUT; j++) begin
            w_cur[j] = '0;
            for (int i = 0; i < N_IN; i++) begin
                if (idx == IDXW'(i)) w_cur[j] = w_mem[i*N_OUT + j];
            end
        end
    end

    always_comb begin
        out_flat = '0;
        for (int j = 0; j < N_OUT; j++) out_flat[j*OUT_W +: OUT_W] = lane_y[j];
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_lane
        dnn_mac_lane #(
            .IN_W (IN_W),
            .W_W  (W_W),
            .ACC_W(ACC_W),
            .OUT_W(OUT_W)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (accept),
            .en     (state == ACCUM),
            .ld     (last),
            .relu_en(relu_lat),
            .x      (x_cur),
            .w      (w_cur[j]),
            .y      (lane_y[j])
        );
    end

endmodule
